// File: rtl/tone_sched.sv
// tone_sched: shares the tone generator between key beeps and BCD result playback.
// Key beeps and playback preemption exist only when TONE_SCHED_BEEP_EN is defined.
module tone_sched #(
   parameter int unsigned NOTE_LEN = 12_500_000,
   parameter int unsigned GAP_LEN  = 2_500_000,
   parameter int unsigned BEEP_LEN = 5_000_000,
   parameter int unsigned CNT_W    = 24
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] num,
   input  logic       numPressed,
   input  logic [2:0] opt,
   input  logic       optPressed,
   input  logic       play,
   input  logic [7:0] byteNum,
   input  logic [1:0] nTimes,
   output logic [3:0] note,
   output logic       note_valid,
   output logic       busy,
   output logic       done
);

`ifdef TONE_SCHED_BEEP_EN
   typedef enum logic [2:0] {IDLE, BEEP, PLAY_HI, GAP_HI, PLAY_LO, GAP_LO} state_t;
`else
   typedef enum logic [2:0] {IDLE, PLAY_HI, GAP_HI, PLAY_LO, GAP_LO} state_t;
`endif

   localparam logic [CNT_W-1:0] NOTE_LAST = CNT_W'(NOTE_LEN - 1);
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_LEN - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [7:0]       byte_q, byte_d;
   logic [1:0]       ntimes_q, ntimes_d;
   logic [1:0]       rep_q, rep_d;
   logic [3:0]       note_q, note_d;
   logic             note_valid_q, note_valid_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic             cnt_zero;
   logic             start;
   logic [7:0]       seq_src;
   logic             first_hi;
   logic [3:0]       first_dig;

   function automatic logic [3:0] digit_note(input logic [3:0] d);
      return (d <= 4'd9) ? d + 4'd1 : 4'd0;
   endfunction

`ifdef TONE_SCHED_BEEP_EN
   localparam logic [CNT_W-1:0] BEEP_LAST = CNT_W'(BEEP_LEN - 1);
   logic       num_prev_q, num_prev_d;
   logic       opt_prev_q, opt_prev_d;
   logic       num_evt, opt_evt, key_evt;
   logic [3:0] beep_note;
   logic [2:0] unused_opt;

   assign unused_opt = opt;
   assign num_evt    = numPressed & ~num_prev_q;
   assign opt_evt    = optPressed & ~opt_prev_q;
   assign key_evt    = num_evt | opt_evt;
   assign beep_note  = num_evt ? ((num > 4'd9) ? 4'hE : num + 4'd1) : 4'hF;
`else
   logic unused_keys;
   assign unused_keys = ^{opt, num, numPressed, optPressed};
`endif

   assign cnt_zero  = (cnt_q == '0);
   // First digit comes from the live input when accepting, else from the latched copy
   assign seq_src   = (state_q == IDLE) ? byteNum : byte_q;
   assign first_hi  = (seq_src[7:4] != 4'd0);
   assign first_dig = first_hi ? seq_src[7:4] : seq_src[3:0];

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_zero ? cnt_q : cnt_q - 1'b1;
      byte_d       = byte_q;
      ntimes_d     = ntimes_q;
      rep_d        = rep_q;
      note_d       = note_q;
      note_valid_d = note_valid_q;
      busy_d       = busy_q;
      done_d       = 1'b0;
      start        = 1'b0;
`ifdef TONE_SCHED_BEEP_EN
      num_prev_d   = numPressed;
      opt_prev_d   = optPressed;
`endif

      case (state_q)
         IDLE: begin
            if (play) begin
               byte_d   = byteNum;
               ntimes_d = nTimes;
               rep_d    = '0;
               start    = 1'b1;
            end
         end
         PLAY_HI: begin
            if (cnt_zero) begin
               state_d      = GAP_HI;
               cnt_d        = GAP_LAST;
               note_d       = '0;
               note_valid_d = 1'b0;
            end
         end
         GAP_HI: begin
            if (cnt_zero) begin
               state_d      = PLAY_LO;
               cnt_d        = NOTE_LAST;
               note_d       = digit_note(byte_q[3:0]);
               note_valid_d = (byte_q[3:0] <= 4'd9);
            end
         end
         PLAY_LO: begin
            if (cnt_zero) begin
               state_d      = GAP_LO;
               cnt_d        = GAP_LAST;
               note_d       = '0;
               note_valid_d = 1'b0;
            end
         end
         GAP_LO: begin
            if (cnt_zero) begin
               if (rep_q < ntimes_q) begin
                  rep_d = rep_q + 2'd1;
                  start = 1'b1;
               end else begin
                  state_d = IDLE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end
            end
         end
`ifdef TONE_SCHED_BEEP_EN
         BEEP: begin
            if (cnt_zero) begin
               state_d      = IDLE;
               note_d       = '0;
               note_valid_d = 1'b0;
               busy_d       = 1'b0;
            end
         end
`endif
         default: begin
            state_d      = IDLE;
            note_d       = '0;
            note_valid_d = 1'b0;
            busy_d       = 1'b0;
         end
      endcase

      if (start) begin
         state_d      = first_hi ? PLAY_HI : PLAY_LO;
         cnt_d        = NOTE_LAST;
         note_d       = digit_note(first_dig);
         note_valid_d = (first_dig <= 4'd9);
         busy_d       = 1'b1;
      end

`ifdef TONE_SCHED_BEEP_EN
      // A key edge overrides everything above, including a same-cycle play or completion
      if (key_evt) begin
         state_d      = BEEP;
         cnt_d        = BEEP_LAST;
         note_d       = beep_note;
         note_valid_d = 1'b1;
         busy_d       = 1'b1;
         done_d       = 1'b0;
         byte_d       = byte_q;
         ntimes_d     = ntimes_q;
         rep_d        = rep_q;
      end
`endif
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         byte_q       <= '0;
         ntimes_q     <= '0;
         rep_q        <= '0;
         note_q       <= '0;
         note_valid_q <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
`ifdef TONE_SCHED_BEEP_EN
         num_prev_q   <= 1'b0;
         opt_prev_q   <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         byte_q       <= byte_d;
         ntimes_q     <= ntimes_d;
         rep_q        <= rep_d;
         note_q       <= note_d;
         note_valid_q <= note_valid_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
`ifdef TONE_SCHED_BEEP_EN
         num_prev_q   <= num_prev_d;
         opt_prev_q   <= opt_prev_d;
`endif
      end
   end

   assign note       = note_q;
   assign note_valid = note_valid_q;
   assign busy       = busy_q;
   assign done       = done_q;

endmodule

// File: tb/tb_tone_sched.sv
// Bench for tone_sched: directed steps then random traffic, checked every cycle
// against a queue-based timeline model built from note/gap/beep durations.
module tb_tone_sched;
   localparam int unsigned NOTE_LEN = 4;
   localparam int unsigned GAP_LEN  = 2;
   localparam int unsigned BEEP_LEN = 3;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [3:0] num = '0;
   logic       numPressed = 1'b0;
   logic [2:0] opt = '0;
   logic       optPressed = 1'b0;
   logic       play = 1'b0;
   logic [7:0] byteNum = '0;
   logic [1:0] nTimes = '0;
   logic [3:0] note;
   logic       note_valid;
   logic       busy;
   logic       done;

   tone_sched #(
      .NOTE_LEN(NOTE_LEN),
      .GAP_LEN (GAP_LEN),
      .BEEP_LEN(BEEP_LEN),
      .CNT_W   (24)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .num       (num),
      .numPressed(numPressed),
      .opt       (opt),
      .optPressed(optPressed),
      .play      (play),
      .byteNum   (byteNum),
      .nTimes    (nTimes),
      .note      (note),
      .note_valid(note_valid),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0] note;
      logic       valid;
      logic       busy;
      logic       done;
   } exp_t;

   exp_t        exp_q[$];
   int unsigned n_vec = 0;
   int unsigned n_err = 0;
   logic        cur_busy = 1'b0;
   logic        prev_np = 1'b0;
   logic        prev_op = 1'b0;

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] expv);
      n_vec++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, expv, $time);
      end
   endtask

   // One digit slot: sounding note (or rest) followed by silence
   task automatic push_slot(input logic [3:0] d);
      exp_t e;
      for (int i = 0; i < NOTE_LEN; i++) begin
         e.note  = (d <= 4'd9) ? d + 4'd1 : 4'd0;
         e.valid = (d <= 4'd9);
         e.busy  = 1'b1;
         e.done  = 1'b0;
         exp_q.push_back(e);
      end
      for (int i = 0; i < GAP_LEN; i++) begin
         e = '0;
         e.busy = 1'b1;
         exp_q.push_back(e);
      end
   endtask

   task automatic push_seq(input logic [7:0] b, input logic [1:0] nt);
      exp_t e;
      for (int r = 0; r <= int'(nt); r++) begin
         if (b[7:4] != 4'd0) push_slot(b[7:4]);
         push_slot(b[3:0]);
      end
      e = '0;
      e.done = 1'b1;
      exp_q.push_back(e);
   endtask

   task automatic model_reset();
      exp_q.delete();
      cur_busy = 1'b0;
      prev_np  = 1'b0;
      prev_op  = 1'b0;
   endtask

   task automatic tick(input logic p, input logic [7:0] b, input logic [1:0] nt,
                       input logic np, input logic [3:0] nm, input logic op);
      exp_t e;
      logic key;
      play       = p;
      byteNum    = b;
      nTimes     = nt;
      numPressed = np;
      num        = nm;
      optPressed = op;
      opt        = 3'($urandom);
      key = 1'b0;
`ifdef TONE_SCHED_BEEP_EN
      key = (np && !prev_np) || (op && !prev_op);
      if (key) begin
         exp_q.delete();
         for (int i = 0; i < BEEP_LEN; i++) begin
            e.note  = (np && !prev_np) ? ((nm > 4'd9) ? 4'hE : nm + 4'd1) : 4'hF;
            e.valid = 1'b1;
            e.busy  = 1'b1;
            e.done  = 1'b0;
            exp_q.push_back(e);
         end
      end
`endif
      if (!key && p && !cur_busy) push_seq(b, nt);
      prev_np = np;
      prev_op = op;
      @(posedge clk);
      @(negedge clk);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : exp_t'('0);
      chk("note", note, e.note);
      chk("note_valid", {3'b0, note_valid}, {3'b0, e.valid});
      chk("busy", {3'b0, busy}, {3'b0, e.busy});
      chk("done", {3'b0, done}, {3'b0, e.done});
      cur_busy = e.busy;
   endtask

   task automatic idle(input int unsigned n);
      for (int unsigned i = 0; i < n; i++) tick(1'b0, 8'h00, 2'd0, 1'b0, 4'd0, 1'b0);
   endtask

   initial begin
      logic       rnp;
      logic       rop;
      logic       rp;
      logic [7:0] rb;

      // Reset state
      #2;
      chk("rst_note", note, 4'd0);
      chk("rst_valid", {3'b0, note_valid}, 4'd0);
      chk("rst_busy", {3'b0, busy}, 4'd0);
      chk("rst_done", {3'b0, done}, 4'd0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;

      // 0x23 once: note 3, gap, note 4, gap, done at T+13
      tick(1'b1, 8'h23, 2'd0, 1'b0, 4'd0, 1'b0);
      chk("p23_first", note, 4'd3);
      idle(5);
      chk("p23_gap", note, 4'd0);
      idle(1);
      chk("p23_lo", note, 4'd4);
      idle(6);
      chk("p23_done", {3'b0, done}, 4'd1);
      chk("p23_idle", {3'b0, busy}, 4'd0);

      // play accepted in the done cycle: 0x07 three times, done at T+19
      tick(1'b1, 8'h07, 2'd2, 1'b0, 4'd0, 1'b0);
      chk("p07_first", note, 4'd8);
      idle(18);
      chk("p07_done", {3'b0, done}, 4'd1);

      // 0x3A: low digit is a rest
      tick(1'b1, 8'h3A, 2'd0, 1'b0, 4'd0, 1'b0);
      chk("p3a_first", note, 4'd4);
      idle(6);
      chk("p3a_rest_note", note, 4'd0);
      chk("p3a_rest_valid", {3'b0, note_valid}, 4'd0);
      chk("p3a_rest_busy", {3'b0, busy}, 4'd1);
      idle(6);
      chk("p3a_done", {3'b0, done}, 4'd1);
      idle(1);

      // 0x00 plays a single 0 (note 1)
      tick(1'b1, 8'h00, 2'd0, 1'b0, 4'd0, 1'b0);
      chk("p00_first", note, 4'd1);
      idle(7);

`ifdef TONE_SCHED_BEEP_EN
      // digit key during PLAY_LO aborts playback
      tick(1'b1, 8'h23, 2'd0, 1'b0, 4'd0, 1'b0);
      idle(7);
      tick(1'b0, 8'h00, 2'd0, 1'b1, 4'd5, 1'b0);
      chk("abort_beep", note, 4'd6);
      tick(1'b0, 8'h00, 2'd0, 1'b1, 4'd5, 1'b0);
      tick(1'b0, 8'h00, 2'd0, 1'b1, 4'd5, 1'b0);
      chk("abort_hold", note, 4'd6);
      tick(1'b0, 8'h00, 2'd0, 1'b0, 4'd0, 1'b0);
      chk("abort_busy", {3'b0, busy}, 4'd0);
      chk("abort_nodone", {3'b0, done}, 4'd0);
      idle(8);

      // digit + operator + play together: digit beep wins, play dropped
      tick(1'b1, 8'h23, 2'd0, 1'b1, 4'd9, 1'b1);
      chk("both_beep", note, 4'hA);
      tick(1'b0, 8'h00, 2'd0, 1'b1, 4'd9, 1'b1);
      tick(1'b0, 8'h00, 2'd0, 1'b1, 4'd9, 1'b1);
      tick(1'b0, 8'h00, 2'd0, 1'b0, 4'd0, 1'b0);
      chk("both_idle", {3'b0, busy}, 4'd0);
      tick(1'b0, 8'h00, 2'd0, 1'b1, 4'd12, 1'b0);
      chk("bad_digit_beep", note, 4'hE);
      tick(1'b0, 8'h00, 2'd0, 1'b0, 4'd0, 1'b1);
      chk("opt_beep", note, 4'hF);
      idle(5);
`else
      // keys are ignored: play goes ahead
      tick(1'b1, 8'h23, 2'd0, 1'b1, 4'd9, 1'b1);
      chk("nokey_play", note, 4'd3);
      idle(13);
`endif

      // asynchronous reset mid-PLAY_HI
      tick(1'b1, 8'h45, 2'd1, 1'b0, 4'd0, 1'b0);
      idle(1);
      #1 reset = 1'b0;
      #1;
      chk("mid_rst_note", note, 4'd0);
      chk("mid_rst_valid", {3'b0, note_valid}, 4'd0);
      chk("mid_rst_busy", {3'b0, busy}, 4'd0);
      chk("mid_rst_done", {3'b0, done}, 4'd0);
      model_reset();
      #1 reset = 1'b1;
      tick(1'b1, 8'h12, 2'd0, 1'b0, 4'd0, 1'b0);
      chk("post_rst_first", note, 4'd2);
      idle(14);

      // random traffic
      rnp = 1'b0;
      rop = 1'b0;
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 11) == 0) rnp = ~rnp;
         if ($urandom_range(0, 15) == 0) rop = ~rop;
         rp = ($urandom_range(0, 5) == 0);
         rb[7:4] = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
         rb[3:0] = 4'($urandom_range(0, 15));
         tick(rp, rb, 2'($urandom_range(0, 3)), rnp, 4'($urandom_range(0, 15)), rop);
      end
      idle(60);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
